// File: rtl/ahb_spi_slave_if.sv
// rtl/ahb_spi_slave_if.sv - AHB-Lite slave terminating bus beats into SPI TX/RX FIFOs
// Writes are packed {addr, data} into TX; reads drain RX, with wait states and a read timeout.
module ahb_spi_slave_if #(
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4,
    parameter int RD_TIMEOUT = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [7:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        tx_valid,
    output logic [7:0]  tx_addr,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready,
    output logic [2:0]  tx_level,
    output logic [2:0]  err_flags
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int CW  = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WDATA, RDATA} state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [2:0]    err_q, err_d;
    logic [TAW:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RAW:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [39:0]   tx_mem_q [TX_DEPTH];
    logic [31:0]   rx_mem_q [RX_DEPTH];

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic hready, accept, timeout_hit, rd_timeout;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic unused_hburst;

    assign unused_hburst = ^HBURST;

    // Pointers carry one extra wrap bit: equal = empty, equal except MSB = full.
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) && (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RAW] != rx_rd_q[RAW]) && (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);

    assign timeout_hit = (wait_q == CW'(RD_TIMEOUT));

    always_comb begin
        hready = 1'b1;
        case (state_q)
            WDATA:   hready = !tx_full;
            RDATA:   hready = !rx_empty || timeout_hit;
            default: hready = 1'b1;
        endcase
    end

    assign accept     = HSEL && HTRANS[1] && hready;
    assign tx_push    = (state_q == WDATA) && hready;
    assign tx_pop     = !tx_empty && tx_ready;
    assign rx_push    = rx_valid && !rx_full;
    assign rx_pop     = (state_q == RDATA) && hready && !rx_empty;
    assign rd_timeout = (state_q == RDATA) && rx_empty && timeout_hit;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        err_d   = err_q;
        if (hready) begin
            wait_d = '0;
            if (accept) begin
                state_d = HWRITE ? WDATA : RDATA;
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == RDATA) begin
            wait_d = wait_q + CW'(1);
        end
        if (accept) begin
            addr_d = HADDR;
            if (HSIZE != 3'b010) begin
                err_d[0] = 1'b1;
            end
            if (HTRANS == 2'b11 && HADDR != addr_q + 8'd4) begin
                err_d[1] = 1'b1;
            end
        end
        if (rd_timeout) begin
            err_d[2] = 1'b1;
        end
    end

    always_comb begin
        tx_wr_d = tx_wr_q + {{TAW{1'b0}}, tx_push};
        tx_rd_d = tx_rd_q + {{TAW{1'b0}}, tx_pop};
        rx_wr_d = rx_wr_q + {{RAW{1'b0}}, rx_push};
        rx_rd_d = rx_rd_q + {{RAW{1'b0}}, rx_pop};
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            tx_wr_q <= tx_wr_d;
            tx_rd_q <= tx_rd_d;
            rx_wr_q <= rx_wr_d;
            rx_rd_q <= rx_rd_d;
        end
    end

    // Storage needs no reset; outputs are gated by the empty flags.
    always_ff @(posedge HCLK) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q[TAW-1:0]] <= {addr_q, HWDATA};
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_q[RAW-1:0]] <= rx_data;
        end
    end

    assign HREADY    = hready;
    assign HRDATA    = (state_q == RDATA && !rx_empty) ? rx_mem_q[rx_rd_q[RAW-1:0]] : 32'h0;
    assign tx_valid  = !tx_empty;
    assign {tx_addr, tx_data} = tx_empty ? 40'h0 : tx_mem_q[tx_rd_q[TAW-1:0]];
    assign rx_ready  = !rx_full;
    assign tx_level  = 3'(tx_wr_q - tx_rd_q);
    assign err_flags = err_q;

endmodule

// File: tb/tb_ahb_spi_slave_if.sv
// tb/tb_ahb_spi_slave_if.sv - bench for ahb_spi_slave_if
module tb_ahb_spi_slave_if;
    localparam int TX_DEPTH   = 4;
    localparam int RX_DEPTH   = 4;
    localparam int RD_TIMEOUT = 16;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [7:0]  HADDR = 8'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [2:0]  HBURST = 3'b000;
    logic [31:0] HWDATA = 32'h0;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        tx_valid;
    logic [7:0]  tx_addr;
    logic [31:0] tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = 32'h0;
    logic        rx_ready;
    logic [2:0]  tx_level;
    logic [2:0]  err_flags;

    ahb_spi_slave_if #(
        .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .tx_valid(tx_valid), .tx_addr(tx_addr),
        .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .tx_level(tx_level), .err_flags(err_flags)
    );

    always #5 HCLK = ~HCLK;

    // Reference model state: expected FIFO contents, data-phase kind, wait count, sticky errors.
    logic [39:0] tx_exp[$];
    logic [31:0] rx_exp[$];
    logic [31:0] wq[$];
    int          dmode = 0;
    logic [7:0]  daddr = 8'h0;
    logic [31:0] dwdata = 32'h0;
    int          wait_m = 0;
    logic [2:0]  err_m = 3'b000;
    logic [7:0]  last_acc = 8'h0;
    int          tx_mode = 0;
    int          rx_mode = 0;
    int          stall_run = 0;
    int          stalls = 0;
    bit          s_rdy;
    int          n_err = 0;
    int          n_checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int   n_tx;
        int   n_rx;
        bit   exp_rdy;
        bit   tx_pop;
        bit   rx_pop;
        logic [31:0] exp_rd;
        tx_ready = (tx_mode == 1) || (tx_mode == 2 && $urandom_range(1) == 1) ||
                   (tx_mode == 3 && stall_run == 3);
        rx_valid = (rx_mode == 1) && ($urandom_range(1) == 1);
        rx_data  = $urandom;
        HWDATA   = dwdata;
        @(negedge HCLK);
        n_tx  = tx_exp.size();
        n_rx  = rx_exp.size();
        s_rdy = HREADY;
        if (dmode == 1)      exp_rdy = (n_tx < TX_DEPTH);
        else if (dmode == 2) exp_rdy = (n_rx > 0) || (wait_m >= RD_TIMEOUT);
        else                 exp_rdy = 1'b1;
        chk("hready", HREADY, exp_rdy);
        exp_rd = (dmode == 2 && n_rx > 0) ? rx_exp[0] : 32'h0;
        chk("hrdata", HRDATA, exp_rd);
        chk("tx_level", tx_level, n_tx);
        chk("tx_valid", tx_valid, n_tx > 0);
        chk("rx_ready", rx_ready, n_rx < RX_DEPTH);
        chk("err_flags", err_flags, err_m);
        tx_pop = tx_ready && (n_tx > 0);
        if (tx_pop) chk("tx_head", {tx_addr, tx_data}, tx_exp[0]);
        rx_pop = (dmode == 2) && s_rdy && (n_rx > 0);
        if (dmode == 2 && s_rdy && n_rx == 0) err_m[2] = 1'b1;
        wait_m = s_rdy ? 0 : ((dmode == 2) ? wait_m + 1 : wait_m);
        if (tx_pop) tx_exp.delete(0);
        if (rx_pop) rx_exp.delete(0);
        if (dmode == 1 && s_rdy) tx_exp.push_back({daddr, dwdata});
        if (rx_valid && n_rx < RX_DEPTH) rx_exp.push_back(rx_data);
        stall_run = s_rdy ? 0 : stall_run + 1;
        if (!s_rdy) stalls++;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        HSEL = 1'b0;
        HTRANS = 2'b00;
        repeat (n) step();
    endtask

    task automatic burst(input bit wr, input logic [7:0] a0, input int n, input int inc,
                         input logic [2:0] size);
        int k = 0;
        int guard = 0;
        logic [7:0] a;
        stalls = 0;
        while ((k < n || dmode != 0) && guard < 200) begin
            a = a0 + 8'(k * inc);
            if (k < n) begin
                HSEL = 1'b1; HTRANS = (k == 0) ? 2'b10 : 2'b11; HADDR = a;
                HWRITE = wr; HSIZE = size; HBURST = (n == 4) ? 3'b011 : 3'b001;
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00;
            end
            step();
            if (s_rdy) begin
                if (k < n) begin
                    if (size != 3'b010) err_m[0] = 1'b1;
                    if (k > 0 && a != last_acc + 8'd4) err_m[1] = 1'b1;
                    last_acc = a;
                    daddr = a;
                    dmode = wr ? 1 : 2;
                    dwdata = (wr && wq.size() > 0) ? wq.pop_front() : $urandom;
                    k++;
                end else begin
                    dmode = 0;
                end
            end
            guard++;
        end
        HSEL = 1'b0;
        HTRANS = 2'b00;
        if (guard >= 200) begin
            n_checks++;
            n_err++;
            $error("FAIL burst_timeout: observed=%0d cycles expected=<200", guard);
        end
    endtask

    initial begin
        #2;
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hready", HREADY, 1'b1);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_head", {tx_addr, tx_data}, 40'h0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_tx_level", tx_level, 3'd0);
        chk("rst_err", err_flags, 3'b000);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        idle(1);

        // INCR4 write, SPI side always ready
        tx_mode = 1;
        wq = '{32'h11, 32'h22, 32'h33, 32'h44};
        burst(1'b1, 8'h10, 4, 4, 3'b010);
        chk("incr4_no_wait", stalls, 0);
        idle(2);
        chk("incr4_err", err_flags, 3'b000);

        // Address wrap 0xFC -> 0x00 is a legal SEQ step
        burst(1'b1, 8'hF8, 4, 4, 3'b010);
        idle(2);
        chk("wrap_err", err_flags, 3'b000);

        // Fill TX, then a fifth write stalls until one pop
        tx_mode = 0;
        burst(1'b1, 8'h10, 4, 4, 3'b010);
        chk("full_level", tx_level, 3'd4);
        tx_mode = 3;
        burst(1'b1, 8'h80, 1, 4, 3'b010);
        chk("full_waits", stalls, 4);
        chk("full_level2", tx_level, 3'd4);
        tx_mode = 1;
        idle(6);

        // Preloaded RX read back with zero wait states
        tx_mode = 0;
        rx_valid = 1'b1;
        rx_data = 32'hA5A5A5A5;
        @(negedge HCLK);
        rx_exp.push_back(rx_data);
        @(posedge HCLK); #1;
        rx_data = 32'h5A5A5A5A;
        @(negedge HCLK);
        rx_exp.push_back(rx_data);
        @(posedge HCLK); #1;
        rx_valid = 1'b0;
        burst(1'b0, 8'h20, 2, 4, 3'b010);
        chk("rd_no_wait", stalls, 0);

        // Read on an empty RX times out
        burst(1'b0, 8'h50, 1, 4, 3'b010);
        chk("rd_timeout_waits", stalls, RD_TIMEOUT);
        chk("rd_timeout_flag", err_flags[2], 1'b1);

        // Sequential address error and size error, data still delivered
        tx_mode = 1;
        burst(1'b1, 8'h28, 2, 8, 3'b010);
        burst(1'b1, 8'h60, 1, 4, 3'b000);
        idle(2);
        chk("seq_size_err", err_flags, 3'b111);

        // Reset in the middle of a burst with two TX entries
        tx_mode = 0;
        burst(1'b1, 8'h70, 2, 4, 3'b010);
        chk("pre_rst_level", tx_level, 3'd2);
        tx_ready = 1'b0; rx_valid = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 8'h78; HWRITE = 1'b1; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HTRANS = 2'b11; HADDR = 8'h7C; HWDATA = 32'hDEAD;
        #2;
        HRESET = 1'b1;
        #1;
        chk("mid_rst_level", tx_level, 3'd0);
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_hready", HREADY, 1'b1);
        chk("mid_rst_err", err_flags, 3'b000);
        HSEL = 1'b0; HTRANS = 2'b00;
        tx_exp.delete(); rx_exp.delete(); wq.delete();
        dmode = 0; wait_m = 0; err_m = 3'b000; last_acc = 8'h0; stall_run = 0; dwdata = 32'h0;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        idle(1);

        // Randomised traffic against the model
        tx_mode = 2;
        rx_mode = 1;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] a0;
            a0 = 8'($urandom) & 8'hFC;
            burst(1'($urandom_range(1)), a0, 1 + $urandom_range(3), 4, 3'b010);
            idle($urandom_range(2));
        end
        tx_mode = 1;
        rx_mode = 0;
        idle(8);
        chk("final_tx_empty", tx_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
